pc_fetch_ctrl: RTL and testbench
================================

# pc_fetch_ctrl

Instruction-fetch control stage of the MIPS core. Holds the architectural program counter and drives it to the `Add_4_PC` incrementer and to instruction memory. Selects the next PC from the incrementer result, branch, jump or jump-register targets. Runs a request/acknowledge handshake with instruction memory and presents the fetched instruction to the IF/ID boundary, honouring hazard stalls and squashing wrong-path fetches.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  synchronous, active-low reset; sampled on CLK rising edge.
- PC  out  32  current PC; feeds `Add_4_PC` input and instruction-memory address.
- PC_S  in  32  PC+4 from `Add_4_PC`.
- BRANCH_TAKEN  in  1  conditional branch resolved taken.
- BRANCH_TARGET  in  32  branch destination.
- JUMP  in  1  J/JAL.
- JUMP_INDEX  in  26  instr_index field.
- JR  in  1  JR/JALR.
- JR_TARGET  in  32  register value.
- STALL  in  1  hazard unit freezes IF/ID.
- IMEM_REQ  out  1  fetch request; PC stable while high.
- IMEM_ACK  in  1  memory returns data this cycle.
- IMEM_RDATA  in  32  instruction word, valid with IMEM_ACK.
- INSTR  out  32  IF/ID instruction.
- INSTR_VALID  out  1  INSTR is a real instruction (0 = bubble).
- PC_PLUS4  out  32  PC+4 of INSTR, for JAL/branch offset.
- MISALIGNED  out  1  sticky trap flag.

## Operation
- Redirect = JR | JUMP | BRANCH_TAKEN. Priority is JR > JUMP > BRANCH.
- Jump target = {PC_S[31:28], JUMP_INDEX, 2'b00}.
- Redirect beats STALL in the same cycle.
- States:
  - FETCH: IMEM_REQ=1.
    - ACK and redirect: discard data; PC<=target; INSTR_VALID<=0.
    - ACK and STALL: RDATA goes to internal buffer; go to HOLD; INSTR and INSTR_VALID hold.
    - ACK only: INSTR<=RDATA; INSTR_VALID<=1; PC_PLUS4<=PC_S; PC<=PC_S.
    - No ACK and redirect: latch target in the pending register; go to SQUASH; INSTR_VALID<=0.
    - No ACK, no redirect: INSTR_VALID<=0 unless STALL, in which case it holds.
  - SQUASH: IMEM_REQ=1 with the old PC until ACK. Discard data; PC<=pending target; go to FETCH; INSTR_VALID<=0. Further redirects while in SQUASH overwrite the pending target.
  - HOLD: IMEM_REQ=0; outputs frozen.
    - Redirect: drop buffer; PC<=target; INSTR_VALID<=0; go to FETCH.
    - STALL low: INSTR<=buffer; INSTR_VALID<=1; PC_PLUS4<=PC_S; PC<=PC_S; go to FETCH.
  - TRAP: entered when any selected target has bits [1:0] != 0. MISALIGNED=1; IMEM_REQ=0; INSTR_VALID=0. Left only by reset.
- PC arithmetic is 32-bit and wraps modulo 2^32 with no flag. 32'hFFFF_FFFC is followed by 32'h0.

## Timing
- Reset (RST_N=0 at an edge) gives:
  - PC=RESET_VECTOR; state FETCH.
  - INSTR=32'h0; INSTR_VALID=0; PC_PLUS4=0; MISALIGNED=0; pending register cleared.
  - IMEM_REQ=1 from the first cycle after reset.
- Reset mid-request abandons it. A late ACK arriving after reset is consumed as the reset-vector fetch only if it arrives while IMEM_REQ=1.
- IMEM_REQ is combinational from state. PC, INSTR, INSTR_VALID and PC_PLUS4 are registered.
- Zero-wait memory (ACK in the same cycle as REQ) sustains one instruction per cycle. Fetch latency is 1 cycle from ACK to INSTR_VALID.
- Redirect penalty: 1 bubble with zero-wait memory; N+1 bubbles with N wait states.
- Handshake rule: PC and IMEM_REQ never change while a request is unacknowledged.

## Structure
- Shared package `mips_pkg` holds:
  - state encoding constants (FETCH, SQUASH, HOLD, TRAP);
  - default RESET_VECTOR;
  - field-width constants (instr_index width = 26).
- One sub-module, `next_pc_sel`: combinational priority mux producing target and redirect flags plus the misalignment check. FSM and registers stay in `pc_fetch_ctrl`.
- `Add_4_PC` is instantiated by the parent, not inside this block.

## Test plan
- Reset release, ACK tied high, RDATA = address: INSTR_VALID rises 1 cycle after reset, then INSTR = 0, 4, 8, … on consecutive cycles; PC_PLUS4 = INSTR+4.
- BRANCH_TAKEN with target 32'h100 at PC 32'h8: one INSTR_VALID=0 bubble; next valid INSTR comes from 32'h100.
- JR=1 and JUMP=1 together (JR_TARGET 32'h200, JUMP_INDEX 26'h40): PC goes to 32'h200.
- ACK delayed 3 cycles with a redirect in cycle 1: PC stays stable while IMEM_REQ=1; the returned word is discarded; the next request uses the target.
- STALL for 4 cycles coincident with ACK: INSTR frozen; IMEM_REQ=0; on release the buffered word appears and PC advances by 4.
- JR_TARGET 32'h202: MISALIGNED=1 and IMEM_REQ=0 until RST_N pulse; after reset PC=RESET_VECTOR.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding, reset vector, instruction field widths.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_INDEX_W        = 26;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HOLD   = 2'd2,
    ST_TRAP   = 2'd3
  } fetch_state_e;

  // J/JAL target: region bits come from PC+4 of the jump.
  function automatic logic [31:0] jump_target(input logic [31:0]              pc_s,
                                               input logic [INSTR_INDEX_W-1:0] idx);
    return {pc_s[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Redirect priority mux (JR > JUMP > BRANCH) with target misalignment check.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0]              pc_s,
  input  logic                     branch_taken,
  input  logic [31:0]              branch_target,
  input  logic                     jump,
  input  logic [INSTR_INDEX_W-1:0] jump_index,
  input  logic                     jr,
  input  logic [31:0]              jr_target,
  output logic                     redirect,
  output logic [31:0]              target,
  output logic                     target_misaligned
);

  always_comb begin
    redirect = jr | jump | branch_taken;
    if (jr) begin
      target = jr_target;
    end else if (jump) begin
      target = jump_target(pc_s, jump_index);
    end else begin
      target = branch_target;
    end
    target_misaligned = redirect && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage control: PC register, imem req/ack handshake, IF/ID instruction register.
// Wrong-path fetches are squashed; stalls park an acknowledged word in a one-entry buffer.
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  output logic [31:0]              PC,
  input  logic [31:0]              PC_S,
  input  logic                     BRANCH_TAKEN,
  input  logic [31:0]              BRANCH_TARGET,
  input  logic                     JUMP,
  input  logic [INSTR_INDEX_W-1:0] JUMP_INDEX,
  input  logic                     JR,
  input  logic [31:0]              JR_TARGET,
  input  logic                     STALL,
  output logic                     IMEM_REQ,
  input  logic                     IMEM_ACK,
  input  logic [31:0]              IMEM_RDATA,
  output logic [31:0]              INSTR,
  output logic                     INSTR_VALID,
  output logic [31:0]              PC_PLUS4,
  output logic                     MISALIGNED
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         vld_q, vld_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  buf_q, buf_d;
  logic         mis_q, mis_d;

  logic         redirect;
  logic [31:0]  target;
  logic         target_mis;

  next_pc_sel u_sel (
    .pc_s              (PC_S),
    .branch_taken      (BRANCH_TAKEN),
    .branch_target     (BRANCH_TARGET),
    .jump              (JUMP),
    .jump_index        (JUMP_INDEX),
    .jr                (JR),
    .jr_target         (JR_TARGET),
    .redirect          (redirect),
    .target            (target),
    .target_misaligned (target_mis)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    pcp4_d  = pcp4_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    mis_d   = mis_q;

    // A misaligned redirect wins over everything and parks the stage until reset.
    if (state_q != ST_TRAP && target_mis) begin
      state_d = ST_TRAP;
      vld_d   = 1'b0;
      mis_d   = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (redirect) begin
            vld_d = 1'b0;
            if (IMEM_ACK) begin
              pc_d = target;
            end else begin
              pend_d  = target;
              state_d = ST_SQUASH;
            end
          end else if (IMEM_ACK) begin
            if (STALL) begin
              buf_d   = IMEM_RDATA;
              state_d = ST_HOLD;
            end else begin
              instr_d = IMEM_RDATA;
              vld_d   = 1'b1;
              pcp4_d  = PC_S;
              pc_d    = PC_S;
            end
          end else if (!STALL) begin
            vld_d = 1'b0;
          end
        end
        ST_SQUASH: begin
          // PC must stay put until the outstanding request is acknowledged.
          vld_d = 1'b0;
          if (IMEM_ACK) begin
            pc_d    = redirect ? target : pend_q;
            state_d = ST_FETCH;
          end else if (redirect) begin
            pend_d = target;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            pc_d    = target;
            vld_d   = 1'b0;
            state_d = ST_FETCH;
          end else if (!STALL) begin
            instr_d = buf_q;
            vld_d   = 1'b1;
            pcp4_d  = PC_S;
            pc_d    = PC_S;
            state_d = ST_FETCH;
          end
        end
        default: begin
          vld_d = 1'b0;
          mis_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      instr_q <= 32'h0;
      vld_q   <= 1'b0;
      pcp4_q  <= 32'h0;
      pend_q  <= 32'h0;
      buf_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      pcp4_q  <= pcp4_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      mis_q   <= mis_d;
    end
  end

  assign IMEM_REQ    = (state_q == ST_FETCH) || (state_q == ST_SQUASH);
  assign PC          = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = vld_q;
  assign PC_PLUS4    = pcp4_q;
  assign MISALIGNED  = mis_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: imem returns its address as data, Add_4_PC modelled inline,
// expected IF/ID words queued by stimulus and popped by an independent monitor.
module tb_pc_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC;
  logic [31:0] PC_S;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [25:0] JUMP_INDEX;
  logic        JR;
  logic [31:0] JR_TARGET;
  logic        STALL;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC_PLUS4;
  logic        MISALIGNED;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_p4_q[$];
  logic [31:0] ei, ep;
  bit          held = 1'b0;

  always #5 CLK = ~CLK;

  assign PC_S       = PC + 32'd4;
  assign IMEM_RDATA = PC;

  pc_fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .PC(PC), .PC_S(PC_S),
    .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .JUMP(JUMP), .JUMP_INDEX(JUMP_INDEX), .JR(JR), .JR_TARGET(JR_TARGET),
    .STALL(STALL), .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .PC_PLUS4(PC_PLUS4), .MISALIGNED(MISALIGNED)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p4);
    exp_instr_q.push_back(i);
    exp_p4_q.push_back(p4);
  endtask

  // A word held under STALL is one delivery, so it is scored only on its first valid cycle.
  always @(negedge CLK) begin
    if (INSTR_VALID && !held) begin
      if (exp_instr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr got %h want none", INSTR);
      end else begin
        ei = exp_instr_q.pop_front();
        ep = exp_p4_q.pop_front();
        chk("instr", INSTR, ei);
        chk("pc_plus4", PC_PLUS4, ep);
      end
    end
    held = INSTR_VALID && STALL;
  end

  initial begin
    RST_N = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    JUMP = 1'b0; JUMP_INDEX = 26'h0; JR = 1'b0; JR_TARGET = 32'h0;
    STALL = 1'b0; IMEM_ACK = 1'b0;
    tick(); tick();
    chk("rst_pc", PC, 32'h0);
    chk("rst_valid", {31'h0, INSTR_VALID}, 32'h0);
    chk("rst_instr", INSTR, 32'h0);
    chk("rst_pc_plus4", PC_PLUS4, 32'h0);
    chk("rst_misaligned", {31'h0, MISALIGNED}, 32'h0);
    chk("rst_req", {31'h0, IMEM_REQ}, 32'h1);

    // Zero-wait streaming from the reset vector.
    push(32'h0, 32'h4); push(32'h4, 32'h8);
    RST_N = 1'b1; IMEM_ACK = 1'b1;
    tick(); chk("stream_pc1", PC, 32'h4);
    tick(); chk("stream_pc2", PC, 32'h8);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100;
    tick(); chk("branch_bubble", {31'h0, INSTR_VALID}, 32'h0);
    chk("branch_pc", PC, 32'h100);
    BRANCH_TAKEN = 1'b0; push(32'h100, 32'h104);
    tick();

    // JR outranks JUMP (JUMP alone would give 32'h100).
    JR = 1'b1; JR_TARGET = 32'h200; JUMP = 1'b1; JUMP_INDEX = 26'h40;
    tick(); chk("jr_prio_pc", PC, 32'h200);
    JR = 1'b0; JUMP = 1'b0; push(32'h200, 32'h204);
    tick();

    // Redirect while the request is pending; ACK returns three cycles later.
    IMEM_ACK = 1'b0; BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h300;
    tick(); chk("sq_pc0", PC, 32'h204); chk("sq_req0", {31'h0, IMEM_REQ}, 32'h1);
    BRANCH_TAKEN = 1'b0;
    tick(); chk("sq_pc1", PC, 32'h204); chk("sq_req1", {31'h0, IMEM_REQ}, 32'h1);
    tick(); chk("sq_pc2", PC, 32'h204);
    IMEM_ACK = 1'b1;
    tick(); chk("sq_target_pc", PC, 32'h300);
    chk("sq_valid", {31'h0, INSTR_VALID}, 32'h0);
    push(32'h300, 32'h304);
    tick();

    // Four-cycle stall coincident with ACK.
    STALL = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_req", {31'h0, IMEM_REQ}, 32'h0);
      chk("stall_instr", INSTR, 32'h300);
      chk("stall_pc", PC, 32'h304);
    end
    STALL = 1'b0; push(32'h304, 32'h308);
    tick(); chk("unstall_pc", PC, 32'h308);

    // Wrap from the top of the address space.
    JR = 1'b1; JR_TARGET = 32'hFFFF_FFFC;
    tick(); chk("wrap_pc", PC, 32'hFFFF_FFFC);
    JR = 1'b0; push(32'hFFFF_FFFC, 32'h0); push(32'h0, 32'h4);
    tick(); chk("wrap_pc0", PC, 32'h0);
    tick(); chk("wrap_pc1", PC, 32'h4);

    // Misaligned JR target traps until reset.
    JR = 1'b1; JR_TARGET = 32'h202;
    tick(); JR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("trap_mis", {31'h0, MISALIGNED}, 32'h1);
      chk("trap_req", {31'h0, IMEM_REQ}, 32'h0);
      chk("trap_valid", {31'h0, INSTR_VALID}, 32'h0);
      tick();
    end
    RST_N = 1'b0;
    tick();
    chk("post_trap_pc", PC, 32'h0);
    chk("post_trap_mis", {31'h0, MISALIGNED}, 32'h0);
    chk("post_trap_req", {31'h0, IMEM_REQ}, 32'h1);
    push(32'h0, 32'h4);
    RST_N = 1'b1;
    tick(); chk("post_trap_fetch_pc", PC, 32'h4);
    IMEM_ACK = 1'b0;
    tick(); chk("idle_valid", {31'h0, INSTR_VALID}, 32'h0);
    tick();
    chk("queue_drained", exp_instr_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
